regfile_arbiter: RTL and testbench

//   Shares the single-port 4x16 register file between two requesters
//   (req0 = fetch/operand path, req1 = ALU writeback). Takes one read or write
//   per grant. Uses round-robin arbitration. Generates clean, registered,
//   one-cycle rEn/wEn strobes with index/data set up one cycle before and held

---
 rtl/regfile_arbiter.sv | 82 ++++++++
 tb/tb_regfile_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sharing of a single-port register file between two requesters,
// issuing registered one-cycle read/write strobes with index/data set up and held around them.
module regfile_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_index,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_index,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] rf_index,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_wEn,
    output logic              rf_rEn,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, CAPTURE} state_t;
    state_t state, state_next;
    logic last_grant, owner, is_write, accept;
    // Gating with reset keeps the readys low while reset is held, even with valids up.
    assign req0_ready = reset && state == IDLE && req0_valid && (!req1_valid || last_grant);
    assign req1_ready = reset && state == IDLE && req1_valid && (!req0_valid || !last_grant);
    assign accept = req0_ready || req1_ready;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? SETUP : IDLE;
            SETUP:   state_next = STROBE;
            STROBE:  state_next = is_write ? IDLE : CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            is_write    <= 1'b0;
            rf_index    <= '0;
            rf_data_in  <= '0;
            rf_wEn      <= 1'b0;
            rf_rEn      <= 1'b0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            if (accept) begin
                owner      <= req1_ready;
                last_grant <= req1_ready;
                is_write   <= req1_ready ? req1_write : req0_write;
                rf_index   <= req1_ready ? req1_index : req0_index;
                rf_data_in <= req1_ready ? (req1_write ? req1_wdata : '0)
                                         : (req0_write ? req0_wdata : '0);
            end
            rf_wEn      <= state == SETUP && is_write;
            rf_rEn      <= state == SETUP && !is_write;
            req0_rvalid <= state == CAPTURE && !owner;
            req1_rvalid <= state == CAPTURE && owner;
            if (state == CAPTURE && !owner) req0_rdata <= rf_data_out;
            if (state == CAPTURE && owner)  req1_rdata <= rf_data_out;
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed and random requests against a cycle-arithmetic reference model,
// with a behavioural register file attached to the rf_* side.
module tb_regfile_arbiter;
    typedef struct packed {logic w; logic [1:0] i; logic [15:0] d;} req_t;
    logic clk = 1'b0, reset = 1'b1;
    logic req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
    logic [1:0] req0_index = 0, req1_index = 0, rf_index;
    logic [15:0] req0_wdata = 0, req1_wdata = 0, req0_rdata, req1_rdata, rf_data_in, rf_data_out;
    logic req0_ready, req1_ready, req0_rvalid, req1_rvalid, rf_wEn, rf_rEn, busy;
    int checks = 0, errors = 0, cyc = 0;
    req_t q0[$], q1[$];
    int glog[$], gcyc[$];
    logic [15:0] rf_mem [4];
    // reference model state: expectations are derived from the accept cycle plus fixed offsets
    logic [15:0] mem [4];
    logic [15:0] exp_rdata [2];
    logic [15:0] exp_din, rv_data;
    logic [1:0] exp_index;
    logic lg, st_wr, rv_own;
    int free_at, st_cyc, rv_cyc;

    regfile_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_index(req0_index),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_index(req1_index),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
        .req1_rdata(req1_rdata),
        .rf_index(rf_index), .rf_data_in(rf_data_in), .rf_wEn(rf_wEn), .rf_rEn(rf_rEn),
        .rf_data_out(rf_data_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) rf_mem[k] <= '0;
            rf_data_out <= '0;
        end else begin
            if (rf_wEn) rf_mem[rf_index] <= rf_data_in;
            if (rf_rEn) rf_data_out <= rf_mem[rf_index];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
            $error("check %s failed", tag);
        end
    endtask

    task automatic do_reset();
        req0_valid = 1; req1_valid = 1;
        reset = 0;
        #1;
        check("rst_wen", rf_wEn, 0);
        check("rst_ren", rf_rEn, 0);
        check("rst_busy", busy, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rvalid", {req0_rvalid, req1_rvalid}, 0);
        check("rst_rdata", {req0_rdata, req1_rdata}, 0);
        check("rst_index", rf_index, 0);
        check("rst_din", rf_data_in, 0);
        req0_valid = 0; req1_valid = 0;
        q0.delete(); q1.delete();
        for (int k = 0; k < 4; k++) mem[k] = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        exp_index = '0; exp_din = '0; lg = 1;
        free_at = 0; st_cyc = -10; rv_cyc = -10; st_wr = 0; rv_own = 0; rv_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        logic v0, v1, r0, r1, be;
        int c;
        req_t it;
        v0 = q0.size() != 0;
        v1 = q1.size() != 0;
        req0_valid = v0;
        req1_valid = v1;
        if (v0) {req0_write, req0_index, req0_wdata} = q0[0];
        else {req0_write, req0_index, req0_wdata} = 19'($urandom);
        if (v1) {req1_write, req1_index, req1_wdata} = q1[0];
        else {req1_write, req1_index, req1_wdata} = 19'($urandom);
        @(negedge clk);
        c = cyc;
        be = c < free_at;
        r0 = !be && v0 && (!v1 || lg);
        r1 = !be && v1 && (!v0 || !lg);
        if (c == rv_cyc) exp_rdata[rv_own] = rv_data;
        check("busy", busy, be);
        check("ready0", req0_ready, r0);
        check("ready1", req1_ready, r1);
        check("wen", rf_wEn, c == st_cyc && st_wr);
        check("ren", rf_rEn, c == st_cyc && !st_wr);
        check("index", rf_index, exp_index);
        check("din", rf_data_in, exp_din);
        check("rvalid0", req0_rvalid, c == rv_cyc && !rv_own);
        check("rvalid1", req1_rvalid, c == rv_cyc && rv_own);
        check("rdata0", req0_rdata, exp_rdata[0]);
        check("rdata1", req1_rdata, exp_rdata[1]);
        if (req0_valid && req0_ready) begin glog.push_back(0); gcyc.push_back(c); end
        if (req1_valid && req1_ready) begin glog.push_back(1); gcyc.push_back(c); end
        if (r0 || r1) begin
            it = r1 ? q1.pop_front() : q0.pop_front();
            lg = r1;
            exp_index = it.i;
            exp_din = it.w ? it.d : '0;
            st_cyc = c + 2;
            st_wr = it.w;
            if (it.w) begin
                mem[it.i] = it.d;
                free_at = c + 3;
            end else begin
                free_at = c + 4;
                rv_cyc = c + 4;
                rv_own = r1;
                rv_data = mem[it.i];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int max);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || cyc < free_at || cyc <= rv_cyc) && n < max) begin
            tick();
            n++;
        end
        check("drain_timeout", n < max, 1);
    endtask

    initial begin
        do_reset();
        // abort a write while its strobe is high
        q0.push_back('{w: 1, i: 2'd1, d: 16'h5555});
        tick();
        tick();
        @(negedge clk);
        check("pre_rst_wen", rf_wEn, 1);
        do_reset();
        // contention right after reset: req0 first, then alternate
        glog.delete(); gcyc.delete();
        q0.push_back('{w: 0, i: 2'd1, d: 16'h0});
        q0.push_back('{w: 0, i: 2'd3, d: 16'h0});
        q1.push_back('{w: 0, i: 2'd2, d: 16'h0});
        q1.push_back('{w: 0, i: 2'd0, d: 16'h0});
        run(100);
        check("grant_count", glog.size(), 4);
        for (int k = 0; k < 4; k++) check($sformatf("grant_order%0d", k), glog[k], k % 2);
        // write then read back the same index
        glog.delete(); gcyc.delete();
        q0.push_back('{w: 1, i: 2'd2, d: 16'hBEEF});
        q0.push_back('{w: 0, i: 2'd2, d: 16'h0});
        run(100);
        check("raw_gap", gcyc[1] - gcyc[0], 3);
        check("raw_rdata", req0_rdata, 16'hBEEF);
        // write streaming from req1, then read back
        glog.delete(); gcyc.delete();
        for (int k = 0; k < 4; k++) q1.push_back('{w: 1, i: 2'(k), d: 16'(k + 1)});
        for (int k = 0; k < 4; k++) q1.push_back('{w: 0, i: 2'(k), d: 16'h0});
        run(200);
        check("thru_count", gcyc.size(), 8);
        for (int k = 1; k < 4; k++) check($sformatf("thru_gap%0d", k), gcyc[k] - gcyc[k-1], 3);
        check("thru_last", req1_rdata, 16'd4);
        // req1 arrives while req0 is in flight
        q0.push_back('{w: 0, i: 2'd3, d: 16'h0});
        tick();
        q1.push_back('{w: 1, i: 2'd3, d: 16'h1234});
        run(100);
        q1.push_back('{w: 0, i: 2'd3, d: 16'h0});
        run(100);
        check("stall_rdata", req1_rdata, 16'h1234);
        // random traffic from both sides
        repeat (400) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 3)
                q0.push_back('{w: 1'($urandom_range(0, 1)), i: 2'($urandom_range(0, 3)), d: 16'($urandom)});
            if ($urandom_range(0, 2) == 0 && q1.size() < 3)
                q1.push_back('{w: 1'($urandom_range(0, 1)), i: 2'($urandom_range(0, 3)), d: 16'($urandom)});
            tick();
        end
        run(200);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
